crack_sched: RTL and testbench

Scheduler for the double-cracking datapath. Splits the RC4 key space between two `crack` cores, launches both with the `en`/`rdy` handshake and collects the first found key. It aborts the losing core and arbitrates the single ciphertext memory (`ct_mem`) read port between the two cores. It sits between the top-level task wrapper and the two `crack` instances.

---
 rtl/crack_pkg.sv | 18 +
 rtl/ct_arb.sv | 73 +++++++
 rtl/crack_sched.sv | 149 ++++++++++++++
 tb/tb_crack_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and constants for the crack scheduler and its ct_mem arbiter.
package crack_pkg;

    localparam int unsigned NCORES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWorking,
        StAbort,
        StDone
    } state_e;

    // Each core's scan base is 0 except for the key MSB, which holds this bit:
    // core0 -> 0, core1 -> 2^(KEY_W-1).
    localparam logic [NCORES-1:0] KEY_BASE_MSB = 2'b10;

endpackage

// File: rtl/ct_arb.sv
// Arbiter for the single ct_mem read port shared by the two crack cores.
// Build option: CRACK_SCHED_RR_EN selects round-robin; otherwise core0 has fixed priority.
import crack_pkg::*;

module ct_arb #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCORES-1:0]        ct_req,
    input  logic [NCORES*ADDR_W-1:0] ct_addr,
    output logic [NCORES-1:0]        ct_gnt,
    output logic [ADDR_W-1:0]        ct_mem_addr,
    input  logic [DATA_W-1:0]        ct_mem_rddata,
    output logic [DATA_W-1:0]        ct_rddata,
    output logic [NCORES-1:0]        ct_rvalid
);

    logic [ADDR_W-1:0] addr_q;
    logic [NCORES-1:0] rvalid_q;

`ifdef CRACK_SCHED_RR_EN
    logic last_q;  // 1 = core1 was granted most recently

    // On contention grant the core that was not granted last.
    always_comb begin
        ct_gnt = ct_req;
        if (ct_req == 2'b11) begin
            ct_gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    // Round-robin pointer follows every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|ct_gnt) begin
            last_q <= ct_gnt[1];
        end
    end
`else
    // Fixed priority: core0 always wins contention.
    always_comb begin
        ct_gnt = {ct_req[1] & ~ct_req[0], ct_req[0]};
    end
`endif

    // Granted address goes straight to the memory; otherwise the last address is held.
    always_comb begin
        ct_mem_addr = addr_q;
        if (ct_gnt[0]) begin
            ct_mem_addr = ct_addr[0 +: ADDR_W];
        end else if (ct_gnt[1]) begin
            ct_mem_addr = ct_addr[ADDR_W +: ADDR_W];
        end
    end

    // Held address and read-valid pipeline matching the 1-cycle memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            rvalid_q <= '0;
        end else begin
            addr_q   <= ct_mem_addr;
            rvalid_q <= ct_gnt;
        end
    end

    assign ct_rvalid = rvalid_q;
    assign ct_rddata = ct_mem_rddata;

endmodule

// File: rtl/crack_sched.sv
// Scheduler for the double-cracking datapath: splits the key space over two crack
// cores, launches them, captures the first found key and aborts the losing core.
// Build option: CRACK_SCHED_RR_EN (round-robin ct_mem arbitration, see ct_arb).
import crack_pkg::*;

module crack_sched #(
    parameter int unsigned KEY_W  = 24,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     rdy,
    output logic                     key_valid,
    output logic [KEY_W-1:0]         key,
    output logic [NCORES-1:0]        c_en,
    output logic [NCORES*KEY_W-1:0]  c_key_base,
    input  logic [NCORES-1:0]        c_rdy,
    input  logic [NCORES-1:0]        c_found,
    input  logic [NCORES*KEY_W-1:0]  c_key,
    output logic [NCORES-1:0]        c_abort,
    input  logic [NCORES-1:0]        ct_req,
    input  logic [NCORES*ADDR_W-1:0] ct_addr,
    output logic [NCORES-1:0]        ct_gnt,
    output logic [ADDR_W-1:0]        ct_mem_addr,
    input  logic [DATA_W-1:0]        ct_mem_rddata,
    output logic [DATA_W-1:0]        ct_rddata,
    output logic [NCORES-1:0]        ct_rvalid
);

    state_e             state_q, state_d;
    logic [NCORES-1:0]  busy_q, busy_d;
    logic [NCORES-1:0]  launch_q;  // cycle right after c_en: core c_rdy not yet meaningful
    logic [NCORES-1:0]  finish;
    logic [NCORES-1:0]  c_abort_q, c_abort_d;
    logic               key_valid_q, key_valid_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               abort_core_q, abort_core_d;
    logic [NCORES-1:0]  c_en_d;

    for (genvar g = 0; g < NCORES; g++) begin : g_base
        assign c_key_base[g*KEY_W +: KEY_W] = {KEY_BASE_MSB[g], {(KEY_W-1){1'b0}}};
    end

    // Next-state, result capture and launch/abort decisions.
    always_comb begin
        state_d      = state_q;
        finish       = busy_q & ~launch_q & c_rdy;
        busy_d       = busy_q & ~finish;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        c_abort_d    = '0;
        abort_core_d = abort_core_q;
        c_en_d       = '0;
        unique case (state_q)
            StIdle, StDone: begin
                if (en) begin
                    state_d     = StStart;
                    key_valid_d = 1'b0;
                    key_d       = '0;
                end
            end
            StStart: begin
                if (c_rdy == 2'b11) begin
                    c_en_d  = 2'b11;
                    busy_d  = 2'b11;
                    state_d = StWorking;
                end
            end
            StWorking: begin
                // Core0 is checked first so it wins a simultaneous find.
                if (finish[0] && c_found[0]) begin
                    key_d       = c_key[0 +: KEY_W];
                    key_valid_d = 1'b1;
                    if (busy_d[1]) begin
                        c_abort_d    = 2'b10;
                        abort_core_d = 1'b1;
                        state_d      = StAbort;
                    end else begin
                        state_d = StDone;
                    end
                end else if (finish[1] && c_found[1]) begin
                    key_d       = c_key[KEY_W +: KEY_W];
                    key_valid_d = 1'b1;
                    if (busy_d[0]) begin
                        c_abort_d    = 2'b01;
                        abort_core_d = 1'b0;
                        state_d      = StAbort;
                    end else begin
                        state_d = StDone;
                    end
                end else if (busy_d == '0) begin
                    state_d = StDone;
                end
            end
            StAbort: begin
                // The aborted core's found flag is deliberately ignored.
                if (finish[abort_core_q]) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            busy_q       <= '0;
            launch_q     <= '0;
            c_abort_q    <= '0;
            key_valid_q  <= 1'b0;
            key_q        <= '0;
            abort_core_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            launch_q     <= c_en_d;
            c_abort_q    <= c_abort_d;
            key_valid_q  <= key_valid_d;
            key_q        <= key_d;
            abort_core_q <= abort_core_d;
        end
    end

    assign rdy       = (state_q == StIdle) || (state_q == StDone);
    assign c_en      = c_en_d;
    assign c_abort   = c_abort_q;
    assign key_valid = key_valid_q;
    assign key       = key_q;

    ct_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ct_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .ct_req        (ct_req),
        .ct_addr       (ct_addr),
        .ct_gnt        (ct_gnt),
        .ct_mem_addr   (ct_mem_addr),
        .ct_mem_rddata (ct_mem_rddata),
        .ct_rddata     (ct_rddata),
        .ct_rvalid     (ct_rvalid)
    );

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched: FSM sequences plus a table of arbiter vectors.
import crack_pkg::*;

module tb_crack_sched;

    localparam int unsigned KEY_W  = 24;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic                   rdy;
    logic                   key_valid;
    logic [KEY_W-1:0]       key;
    logic [1:0]             c_en;
    logic [2*KEY_W-1:0]     c_key_base;
    logic [1:0]             c_rdy;
    logic [1:0]             c_found;
    logic [2*KEY_W-1:0]     c_key;
    logic [1:0]             c_abort;
    logic [1:0]             ct_req;
    logic [2*ADDR_W-1:0]    ct_addr;
    logic [1:0]             ct_gnt;
    logic [ADDR_W-1:0]      ct_mem_addr;
    logic [DATA_W-1:0]      ct_mem_rddata;
    logic [DATA_W-1:0]      ct_rddata;
    logic [1:0]             ct_rvalid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Memory model: data is a fixed function of the address, one cycle late.
    always @(posedge clk) ct_mem_rddata <= ct_mem_addr ^ 8'hA5;

    crack_sched #(
        .KEY_W  (KEY_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .rdy           (rdy),
        .key_valid     (key_valid),
        .key           (key),
        .c_en          (c_en),
        .c_key_base    (c_key_base),
        .c_rdy         (c_rdy),
        .c_found       (c_found),
        .c_key         (c_key),
        .c_abort       (c_abort),
        .ct_req        (ct_req),
        .ct_addr       (ct_addr),
        .ct_gnt        (ct_gnt),
        .ct_mem_addr   (ct_mem_addr),
        .ct_mem_rddata (ct_mem_rddata),
        .ct_rddata     (ct_rddata),
        .ct_rvalid     (ct_rvalid)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic [7:0] addr;
        logic [1:0] rvalid;
    } arb_vec_t;

    arb_vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input state_e exp);
        chk(name, 64'(dut.state_q), 64'(exp));
    endtask

    initial begin
        logic [7:0] prev_addr;

`ifdef CRACK_SCHED_RR_EN
        vecs[0] = '{2'b00, 2'b00, 8'h00, 2'b00};
        vecs[1] = '{2'b11, 2'b01, 8'h10, 2'b00};
        vecs[2] = '{2'b11, 2'b10, 8'h20, 2'b01};
        vecs[3] = '{2'b11, 2'b01, 8'h10, 2'b10};
        vecs[4] = '{2'b10, 2'b10, 8'h20, 2'b01};
        vecs[5] = '{2'b00, 2'b00, 8'h20, 2'b10};
        vecs[6] = '{2'b00, 2'b00, 8'h20, 2'b00};
`else
        vecs[0] = '{2'b00, 2'b00, 8'h00, 2'b00};
        vecs[1] = '{2'b11, 2'b01, 8'h10, 2'b00};
        vecs[2] = '{2'b11, 2'b01, 8'h10, 2'b01};
        vecs[3] = '{2'b11, 2'b01, 8'h10, 2'b01};
        vecs[4] = '{2'b10, 2'b10, 8'h20, 2'b01};
        vecs[5] = '{2'b00, 2'b00, 8'h20, 2'b10};
        vecs[6] = '{2'b00, 2'b00, 8'h20, 2'b00};
`endif

        rst_n   = 1'b0;
        en      = 1'b0;
        c_rdy   = 2'b00;
        c_found = 2'b00;
        c_key   = '0;
        ct_req  = 2'b00;
        ct_addr = {8'h20, 8'h10};

        // Reset values
        #12;
        chk("rst_rdy", 64'(rdy), 64'd1);
        chk("rst_key_valid", 64'(key_valid), 64'd0);
        chk("rst_key", 64'(key), 64'd0);
        chk("rst_c_en", 64'(c_en), 64'd0);
        chk("rst_c_abort", 64'(c_abort), 64'd0);
        chk("rst_ct_gnt", 64'(ct_gnt), 64'd0);
        chk("rst_ct_rvalid", 64'(ct_rvalid), 64'd0);
        chk("rst_ct_mem_addr", 64'(ct_mem_addr), 64'd0);
        chk("key_base", 64'(c_key_base), {16'h0, 24'h800000, 24'h000000});
        chk_state("rst_state", StIdle);
        next_cycle();
        rst_n = 1'b1;

        // Launch waits for both cores ready, then core1 wins while core0 is busy
        en    = 1'b1;
        c_rdy = 2'b01;
        @(negedge clk);
        chk_state("a_idle", StIdle);
        next_cycle();
        en = 1'b0;
        @(negedge clk);
        chk_state("a_start", StStart);
        chk("a_start_rdy", 64'(rdy), 64'd0);
        chk("a_start_wait_c_en", 64'(c_en), 64'd0);
        next_cycle();
        c_rdy = 2'b11;
        @(negedge clk);
        chk("a_launch_c_en", 64'(c_en), 64'd3);
        next_cycle();
        c_found = 2'b10;  // stale ready/found right after launch must be ignored
        c_key   = {24'h800018, 24'h000000};
        @(negedge clk);
        chk_state("a_working", StWorking);
        chk("a_c_en_pulse", 64'(c_en), 64'd0);
        next_cycle();
        c_rdy = 2'b10;
        @(negedge clk);
        chk("a_kv_not_yet", 64'(key_valid), 64'd0);
        next_cycle();
        c_rdy   = 2'b00;
        c_found = 2'b00;
        @(negedge clk);
        chk("a_key", 64'(key), 64'h800018);
        chk("a_key_valid", 64'(key_valid), 64'd1);
        chk("a_abort_pulse", 64'(c_abort), 64'd1);
        chk_state("a_abort_state", StAbort);
        next_cycle();
        @(negedge clk);
        chk("a_abort_end", 64'(c_abort), 64'd0);
        chk_state("a_abort_wait", StAbort);
        next_cycle();
        c_rdy   = 2'b01;
        c_found = 2'b01;  // loser's find is ignored
        c_key   = {24'h800018, 24'h000077};
        @(negedge clk);
        chk_state("a_abort_seen", StAbort);
        next_cycle();
        c_found = 2'b00;
        @(negedge clk);
        chk_state("a_done", StDone);
        chk("a_done_key", 64'(key), 64'h800018);
        chk("a_done_rdy", 64'(rdy), 64'd1);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            chk_state("a_done_sticky", StDone);
        end

        // Both cores find in the same cycle: core0 wins, no abort
        next_cycle();
        c_rdy = 2'b11;
        en    = 1'b1;
        next_cycle();
        en = 1'b0;
        @(negedge clk);
        chk_state("b_start", StStart);
        chk("b_kv_cleared", 64'(key_valid), 64'd0);
        chk("b_key_cleared", 64'(key), 64'd0);
        chk("b_min_latency_c_en", 64'(c_en), 64'd3);
        next_cycle();
        c_rdy = 2'b00;
        @(negedge clk);
        chk_state("b_working", StWorking);
        next_cycle();
        c_rdy   = 2'b11;
        c_found = 2'b11;
        c_key   = {24'h800001, 24'h000018};
        next_cycle();
        c_found = 2'b00;
        @(negedge clk);
        chk("b_key", 64'(key), 64'h000018);
        chk("b_key_valid", 64'(key_valid), 64'd1);
        chk("b_no_abort", 64'(c_abort), 64'd0);
        chk_state("b_done", StDone);

        // Neither core finds: DONE without a key, then relaunch
        en = 1'b1;
        next_cycle();
        en = 1'b0;
        next_cycle();
        c_rdy = 2'b00;
        next_cycle();
        c_rdy = 2'b01;
        next_cycle();
        c_rdy = 2'b11;
        @(negedge clk);
        chk_state("c_one_left", StWorking);
        next_cycle();
        @(negedge clk);
        chk_state("c_done", StDone);
        chk("c_key_valid", 64'(key_valid), 64'd0);
        chk("c_rdy_out", 64'(rdy), 64'd1);
        en = 1'b1;
        next_cycle();
        en = 1'b0;
        @(negedge clk);
        chk("c_relaunch", 64'(c_en), 64'd3);
        next_cycle();
        c_rdy = 2'b00;  // keep both cores busy through the arbiter vectors

        // Arbiter vectors, applied while the FSM sits in WORKING
        prev_addr = 8'h00;
        for (int i = 0; i < 7; i++) begin
            ct_req = vecs[i].req;
            @(negedge clk);
            chk($sformatf("arb%0d_gnt", i), 64'(ct_gnt), 64'(vecs[i].gnt));
            chk($sformatf("arb%0d_addr", i), 64'(ct_mem_addr), 64'(vecs[i].addr));
            chk($sformatf("arb%0d_rvalid", i), 64'(ct_rvalid), 64'(vecs[i].rvalid));
            if (vecs[i].rvalid != 2'b00) begin
                chk($sformatf("arb%0d_rddata", i), 64'(ct_rddata), 64'(prev_addr ^ 8'hA5));
            end
            prev_addr = vecs[i].addr;
            next_cycle();
        end
        chk_state("arb_still_working", StWorking);

        // Asynchronous reset in the middle of WORKING
        ct_req = 2'b01;
        #3;
        ct_req = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        chk_state("r_state", StIdle);
        chk("r_rdy", 64'(rdy), 64'd1);
        chk("r_busy", 64'(dut.busy_q), 64'd0);
        chk("r_c_abort", 64'(c_abort), 64'd0);
        chk("r_c_en", 64'(c_en), 64'd0);
        chk("r_ct_mem_addr", 64'(ct_mem_addr), 64'd0);
        chk("r_ct_rvalid", 64'(ct_rvalid), 64'd0);
        chk("r_key_valid", 64'(key_valid), 64'd0);
        #3;
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk_state("r_idle_after", StIdle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
